act_compress: RTL and testbench

ACT_COMPRESS -- requirements
Module: act_compress

---
 rtl/act_compress_pkg.sv | 9 +
 rtl/act_compress.sv | 126 ++++++++++++
 tb/tb_act_compress.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/act_compress_pkg.sv
// rtl/act_compress_pkg.sv - shared activation-buffer geometry used by the compressor.
package act_compress_pkg;

    localparam int GBF_BLOCK_DEPTH    = 32;
    localparam int GBF_DATA_WIDTH     = 8;
    localparam int GBF_ACT_ADDR_WIDTH = 12;
    localparam int GBF_MAX_BLK        = 16;

endpackage

// File: rtl/act_compress.sv
// rtl/act_compress.sv - dense activation stream to nonzero-value buffer plus per-block flag words.
module act_compress
    import act_compress_pkg::*;
#(
    parameter int BLOCK_DEPTH = GBF_BLOCK_DEPTH,
    parameter int DATA_WIDTH  = GBF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = GBF_ACT_ADDR_WIDTH,
    parameter int MAX_BLK     = GBF_MAX_BLK
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   in_val,
    output logic                   in_rdy,
    input  logic [DATA_WIDTH-1:0]  in_dat,
    input  logic                   in_last,
    output logic                   act_wen,
    output logic [ADDR_WIDTH-1:0]  act_waddr,
    output logic [DATA_WIDTH-1:0]  act_wdat,
    output logic                   flg_wen,
    output logic [ADDR_WIDTH-1:0]  flg_waddr,
    output logic [BLOCK_DEPTH-1:0] flg_wdat,
    input  logic                   blk_rel,
    output logic                   act_val,
    output logic                   done
);

    localparam int POS_W = (BLOCK_DEPTH > 1) ? $clog2(BLOCK_DEPTH) : 1;
    localparam int CNT_W = $clog2(MAX_BLK + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] WRFLG   = 2'd2;

    localparam logic [POS_W-1:0] POS_LAST = POS_W'(BLOCK_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BLK);

    logic [1:0]             state;
    logic [POS_W-1:0]       pos;
    logic [BLOCK_DEPTH-1:0] shadowFlg;
    logic [CNT_W-1:0]       blkCnt;
    logic [ADDR_WIDTH-1:0]  actPtr;
    logic [ADDR_WIDTH-1:0]  flgPtr;

    logic                   accept;
    logic                   datNz;
    logic                   blkEnd;
    logic                   relOk;
    logic [BLOCK_DEPTH-1:0] curBit;

    assign in_rdy    = (state == COLLECT) && (blkCnt < CNT_MAX);
    assign accept    = in_val && in_rdy;
    assign datNz     = |in_dat;
    assign blkEnd    = accept && ((pos == POS_LAST) || in_last);
    assign curBit    = BLOCK_DEPTH'(datNz) << pos;
    assign relOk     = blk_rel && (blkCnt != '0);
    assign act_waddr = actPtr;
    assign flg_waddr = flgPtr;
    assign act_val   = (blkCnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pos       <= '0;
            shadowFlg <= '0;
            blkCnt    <= '0;
            actPtr    <= '0;
            flgPtr    <= '0;
            act_wen   <= 1'b0;
            act_wdat  <= '0;
            flg_wen   <= 1'b0;
            flg_wdat  <= '0;
            done      <= 1'b0;
        end else begin
            act_wen <= accept && datNz;
            if (accept && datNz) begin
                act_wdat <= in_dat;
            end
            // The flag word is assembled at the closing accept so it already holds the last bit.
            flg_wen <= blkEnd;
            done    <= blkEnd && in_last;
            if (blkEnd) begin
                flg_wdat <= shadowFlg | curBit;
            end

            if (act_wen) begin
                actPtr <= actPtr + ADDR_WIDTH'(1);
            end
            if (flg_wen) begin
                flgPtr <= flgPtr + ADDR_WIDTH'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        shadowFlg <= shadowFlg | curBit;
                        if (blkEnd) begin
                            state <= WRFLG;
                            pos   <= '0;
                        end else begin
                            pos <= pos + POS_W'(1);
                        end
                    end
                end
                WRFLG: begin
                    shadowFlg <= '0;
                    // done is high here only when the block closed the frame.
                    state     <= done ? IDLE : COLLECT;
                end
                default: state <= IDLE;
            endcase

            if (flg_wen && !relOk) begin
                blkCnt <= blkCnt + CNT_W'(1);
            end else if (!flg_wen && relOk) begin
                blkCnt <= blkCnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_act_compress.sv
// tb/tb_act_compress.sv - directed self-checking bench for act_compress.
module tb_act_compress;

    localparam int BD = 32;
    localparam int DW = 8;
    localparam int AW = 12;
    localparam int MB = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_val = 1'b0;
    logic          in_rdy;
    logic [DW-1:0] in_dat = '0;
    logic          in_last = 1'b0;
    logic          act_wen;
    logic [AW-1:0] act_waddr;
    logic [DW-1:0] act_wdat;
    logic          flg_wen;
    logic [AW-1:0] flg_waddr;
    logic [BD-1:0] flg_wdat;
    logic          blk_rel = 1'b0;
    logic          act_val;
    logic          done;

    int testsRun = 0;
    int testsFailed = 0;
    int strayDone = 0;
    logic [AW-1:0] expAct = '0;
    logic [AW-1:0] expFlg = '0;

    logic [AW+DW-1:0]  actQ[$];
    logic [AW+BD:0]    flgQ[$];

    act_compress #(
        .BLOCK_DEPTH(BD),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MAX_BLK    (MB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_dat   (in_dat),
        .in_last  (in_last),
        .act_wen  (act_wen),
        .act_waddr(act_waddr),
        .act_wdat (act_wdat),
        .flg_wen  (flg_wen),
        .flg_waddr(flg_waddr),
        .flg_wdat (flg_wdat),
        .blk_rel  (blk_rel),
        .act_val  (act_val),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (act_wen) actQ.push_back({act_waddr, act_wdat});
        if (flg_wen) flgQ.push_back({done, flg_waddr, flg_wdat});
        if (done && !flg_wen) strayDone++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulseRel();
        blk_rel = 1'b1;
        tick();
        blk_rel = 1'b0;
    endtask

    task automatic sendElem(input logic [DW-1:0] d, input logic l);
        int n;
        n = 0;
        in_val = 1'b1;
        in_dat = d;
        in_last = l;
        while (!in_rdy && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            testsRun++;
            testsFailed++;
            $display("FAIL send_timeout in_rdy=%0b after %0d cycles, required 1", in_rdy, n);
        end
        tick();
        in_val = 1'b0;
        in_last = 1'b0;
        in_dat = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        testsRun++;
        if ({in_rdy, act_wen, flg_wen, act_val, done} !== 5'b0) begin
            testsFailed++;
            $display("FAIL reset_ctrl got %b want 00000", {in_rdy, act_wen, flg_wen, act_val, done});
        end
        testsRun++;
        if ({act_wdat, flg_wdat} !== '0) begin
            testsFailed++;
            $display("FAIL reset_wdat got %h want 0", {act_wdat, flg_wdat});
        end
        testsRun++;
        if ({act_waddr, flg_waddr} !== '0) begin
            testsFailed++;
            $display("FAIL reset_waddr got %h want 0", {act_waddr, flg_waddr});
        end
        rst_n = 1'b1;
        in_val = 1'b1;
        tick();
        tick();
        testsRun++;
        if ({in_rdy, act_wen} !== 2'b00) begin
            testsFailed++;
            $display("FAIL idle_no_rdy got %b want 00", {in_rdy, act_wen});
        end
        in_val = 1'b0;
    endtask

    task automatic test_full_block();
        logic [AW+DW-1:0] e;
        actQ.delete();
        flgQ.delete();
        pulseStart();
        for (int i = 0; i < BD; i++) sendElem(DW'(i + 1), 1'b0);
        tick();
        tick();
        testsRun++;
        if (actQ.size() !== 32) begin
            testsFailed++;
            $display("FAIL full_act_count got %0d want 32", actQ.size());
        end else begin
            for (int i = 0; i < 32; i++) begin
                e = {expAct + AW'(i), DW'(i + 1)};
                testsRun++;
                if (actQ[i] !== e) begin
                    testsFailed++;
                    $display("FAIL full_act_%0d got %h want %h", i, actQ[i], e);
                end
            end
        end
        testsRun++;
        if (flgQ.size() !== 1 || flgQ[0] !== {1'b0, expFlg, 32'hFFFF_FFFF}) begin
            testsFailed++;
            $display("FAIL full_flag got n=%0d %h want %h", flgQ.size(), flgQ[0], {1'b0, expFlg, 32'hFFFF_FFFF});
        end
        testsRun++;
        if (act_val !== 1'b1) begin
            testsFailed++;
            $display("FAIL full_act_val got %b want 1", act_val);
        end
        pulseRel();
        testsRun++;
        if (act_val !== 1'b0) begin
            testsFailed++;
            $display("FAIL full_rel_act_val got %b want 0", act_val);
        end
        expAct += 32;
        expFlg += 1;
    endtask

    task automatic test_sparse();
        logic [DW-1:0] d;
        actQ.delete();
        flgQ.delete();
        pulseStart();
        for (int i = 0; i < BD; i++) begin
            d = (i == 0) ? 8'h11 : (i == 5) ? 8'h22 : (i == 31) ? 8'h33 : 8'h00;
            sendElem(d, 1'b0);
        end
        tick();
        tick();
        testsRun++;
        if (actQ.size() !== 3 || actQ[0] !== {expAct, 8'h11} || actQ[1] !== {expAct + 12'd1, 8'h22}
            || actQ[2] !== {expAct + 12'd2, 8'h33}) begin
            testsFailed++;
            $display("FAIL sparse_acts got n=%0d %h %h %h want %h %h %h", actQ.size(), actQ[0], actQ[1], actQ[2],
                     {expAct, 8'h11}, {expAct + 12'd1, 8'h22}, {expAct + 12'd2, 8'h33});
        end
        testsRun++;
        if (flgQ.size() !== 1 || flgQ[0] !== {1'b0, expFlg, 32'h8000_0021}) begin
            testsFailed++;
            $display("FAIL sparse_flag got n=%0d %h want %h", flgQ.size(), flgQ[0], {1'b0, expFlg, 32'h8000_0021});
        end
        pulseRel();
        expAct += 3;
        expFlg += 1;
    endtask

    task automatic test_short_frame();
        actQ.delete();
        flgQ.delete();
        for (int i = 0; i < 10; i++) sendElem(DW'(i + 1), i == 9);
        tick();
        tick();
        testsRun++;
        if (actQ.size() !== 10 || actQ[9] !== {expAct + 12'd9, 8'd10}) begin
            testsFailed++;
            $display("FAIL short_acts got n=%0d last=%h want 10 %h", actQ.size(), actQ[9], {expAct + 12'd9, 8'd10});
        end
        testsRun++;
        if (flgQ.size() !== 1 || flgQ[0] !== {1'b1, expFlg, 32'h0000_03FF}) begin
            testsFailed++;
            $display("FAIL short_flag_done got n=%0d %h want %h", flgQ.size(), flgQ[0], {1'b1, expFlg, 32'h0000_03FF});
        end
        testsRun++;
        if (in_rdy !== 1'b0 || strayDone !== 0) begin
            testsFailed++;
            $display("FAIL short_idle got in_rdy=%b stray=%0d want 0 0", in_rdy, strayDone);
        end
        pulseRel();
        expAct += 10;
        expFlg += 1;
    endtask

    task automatic test_credit_stall();
        actQ.delete();
        flgQ.delete();
        pulseStart();
        for (int i = 0; i < 2 * BD; i++) sendElem(8'h5A, 1'b0);
        tick();
        testsRun++;
        if (in_rdy !== 1'b0 || act_val !== 1'b1) begin
            testsFailed++;
            $display("FAIL stall_rdy got in_rdy=%b act_val=%b want 0 1", in_rdy, act_val);
        end
        in_val = 1'b1;
        in_dat = 8'h77;
        for (int i = 0; i < 5; i++) tick();
        testsRun++;
        if (actQ.size() !== 64 || flgQ.size() !== 2 || in_rdy !== 1'b0) begin
            testsFailed++;
            $display("FAIL stall_hold got acts=%0d flags=%0d in_rdy=%b want 64 2 0", actQ.size(), flgQ.size(), in_rdy);
        end
        in_val = 1'b0;
        pulseRel();
        testsRun++;
        if (in_rdy !== 1'b1) begin
            testsFailed++;
            $display("FAIL stall_resume got in_rdy=%b want 1", in_rdy);
        end
        for (int i = 0; i < BD; i++) sendElem(8'h77, i == BD - 1);
        tick();
        tick();
        testsRun++;
        if (flgQ.size() !== 3 || flgQ[1] !== {1'b0, expFlg + 12'd1, 32'hFFFF_FFFF}
            || flgQ[2] !== {1'b1, expFlg + 12'd2, 32'hFFFF_FFFF}) begin
            testsFailed++;
            $display("FAIL stall_flags got n=%0d %h %h want 3", flgQ.size(), flgQ[1], flgQ[2]);
        end
        testsRun++;
        if (actQ.size() !== 96 || actQ[95] !== {expAct + 12'd95, 8'h77}) begin
            testsFailed++;
            $display("FAIL stall_acts got n=%0d last=%h want 96 %h", actQ.size(), actQ[95], {expAct + 12'd95, 8'h77});
        end
        pulseRel();
        testsRun++;
        if (act_val !== 1'b1) begin
            testsFailed++;
            $display("FAIL stall_cnt_one got act_val=%b want 1", act_val);
        end
        pulseRel();
        testsRun++;
        if (act_val !== 1'b0) begin
            testsFailed++;
            $display("FAIL stall_cnt_zero got act_val=%b want 0", act_val);
        end
        expAct += 96;
        expFlg += 3;
    endtask

    task automatic test_simultaneous();
        actQ.delete();
        flgQ.delete();
        pulseStart();
        for (int i = 0; i < BD; i++) sendElem(8'h00, 1'b0);
        sendElem(8'h01, 1'b0);
        sendElem(8'h00, 1'b0);
        sendElem(8'h02, 1'b0);
        sendElem(8'h03, 1'b1);
        blk_rel = 1'b1;
        tick();
        blk_rel = 1'b0;
        tick();
        testsRun++;
        if (act_val !== 1'b1) begin
            testsFailed++;
            $display("FAIL simul_cnt_kept got act_val=%b want 1", act_val);
        end
        pulseRel();
        testsRun++;
        if (act_val !== 1'b0) begin
            testsFailed++;
            $display("FAIL simul_cnt_drain got act_val=%b want 0", act_val);
        end
        testsRun++;
        if (flgQ.size() !== 2 || flgQ[0] !== {1'b0, expFlg, 32'h0}
            || flgQ[1] !== {1'b1, expFlg + 12'd1, 32'h0000_000D}) begin
            testsFailed++;
            $display("FAIL simul_flags got n=%0d %h %h want %h %h", flgQ.size(), flgQ[0], flgQ[1],
                     {1'b0, expFlg, 32'h0}, {1'b1, expFlg + 12'd1, 32'h0000_000D});
        end
        testsRun++;
        if (actQ.size() !== 3 || actQ[0] !== {expAct, 8'h01} || actQ[2] !== {expAct + 12'd2, 8'h03}) begin
            testsFailed++;
            $display("FAIL simul_acts got n=%0d %h %h want 3 %h %h", actQ.size(), actQ[0], actQ[2],
                     {expAct, 8'h01}, {expAct + 12'd2, 8'h03});
        end
        expAct += 3;
        expFlg += 2;
    endtask

    task automatic test_wrap();
        logic [AW+DW-1:0] e;
        logic seenWrap;
        pulseStart();
        while (expAct < 12'hFC0) begin
            actQ.delete();
            flgQ.delete();
            for (int i = 0; i < BD; i++) sendElem(8'hC3, 1'b0);
            tick();
            pulseRel();
            expAct += 32;
            expFlg += 1;
        end
        actQ.delete();
        flgQ.delete();
        for (int i = 0; i < 2 * BD; i++) sendElem(8'hA5, i == 2 * BD - 1);
        tick();
        tick();
        seenWrap = 1'b0;
        testsRun++;
        if (actQ.size() !== 64) begin
            testsFailed++;
            $display("FAIL wrap_count got %0d want 64", actQ.size());
        end else begin
            for (int i = 0; i < 64; i++) begin
                e = {expAct + AW'(i), 8'hA5};
                testsRun++;
                if (actQ[i] !== e) begin
                    testsFailed++;
                    $display("FAIL wrap_act_%0d got %h want %h", i, actQ[i], e);
                end
                if (i > 0 && actQ[i-1][19:8] == 12'hFFF && actQ[i][19:8] == 12'h000) seenWrap = 1'b1;
            end
        end
        testsRun++;
        if (seenWrap !== 1'b1) begin
            testsFailed++;
            $display("FAIL wrap_fff_to_000 got %b want 1", seenWrap);
        end
        testsRun++;
        if (flgQ.size() !== 2 || flgQ[1] !== {1'b1, expFlg + 12'd1, 32'hFFFF_FFFF}) begin
            testsFailed++;
            $display("FAIL wrap_flags got n=%0d %h want %h", flgQ.size(), flgQ[1], {1'b1, expFlg + 12'd1, 32'hFFFF_FFFF});
        end
        pulseRel();
        pulseRel();
        expAct += 64;
        expFlg += 2;
    endtask

    task automatic test_reset_mid_block();
        pulseStart();
        for (int i = 0; i < 7; i++) sendElem(DW'(8'h40 + i), 1'b0);
        flgQ.delete();
        rst_n = 1'b0;
        #1;
        testsRun++;
        if ({in_rdy, act_wen, flg_wen, act_val, done} !== 5'b0 || {act_wdat, flg_wdat} !== '0) begin
            testsFailed++;
            $display("FAIL midrst_outputs got ctrl=%b wdat=%h want 0", {in_rdy, act_wen, flg_wen, act_val, done},
                     {act_wdat, flg_wdat});
        end
        testsRun++;
        if ({act_waddr, flg_waddr} !== '0) begin
            testsFailed++;
            $display("FAIL midrst_ptrs got %h want 0", {act_waddr, flg_waddr});
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        testsRun++;
        if (flgQ.size() !== 0) begin
            testsFailed++;
            $display("FAIL midrst_no_flag got %0d want 0", flgQ.size());
        end
        expAct = '0;
        expFlg = '0;
        actQ.delete();
        flgQ.delete();
        pulseStart();
        sendElem(8'h01, 1'b0);
        sendElem(8'h00, 1'b0);
        sendElem(8'h02, 1'b1);
        tick();
        tick();
        testsRun++;
        if (flgQ.size() !== 1 || flgQ[0] !== {1'b1, 12'h000, 32'h0000_0005}) begin
            testsFailed++;
            $display("FAIL midrst_next_flag got n=%0d %h want %h", flgQ.size(), flgQ[0], {1'b1, 12'h000, 32'h0000_0005});
        end
        testsRun++;
        if (actQ.size() !== 2 || actQ[0] !== {12'h000, 8'h01} || actQ[1] !== {12'h001, 8'h02}) begin
            testsFailed++;
            $display("FAIL midrst_next_acts got n=%0d %h %h want 00001 00102", actQ.size(), actQ[0], actQ[1]);
        end
        testsRun++;
        if (strayDone !== 0) begin
            testsFailed++;
            $display("FAIL stray_done got %0d want 0", strayDone);
        end
    endtask

    initial begin
        test_reset();
        test_full_block();
        test_sparse();
        test_short_frame();
        test_credit_stall();
        test_simultaneous();
        test_wrap();
        test_reset_mid_block();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
